// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic light controller with pedestrian cut-short and flashing-yellow
// maintenance mode. The lamps, the walk signal and the phase are decoded directly
// from the state register, so an asynchronous reset takes effect on the outputs
// at once.
//
// state  | meaning
// MAIN_G | main road green, side road red
// MAIN_Y | main road yellow, side road red
// ALL_R1 | clearance before side green, both red
// SIDE_G | side road green, main road red, walk on
// SIDE_Y | side road yellow, main road red
// ALL_R2 | clearance before main green, both red
// FLASH  | maintenance, both lamps blink yellow
module traffic_light_ctrl_param #(
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int MIN_GREEN = 4,
  parameter int FLASH_T   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5,
    FLASH  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_T - 1);

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_R   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b100;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] flash_cnt;
  logic             flash_tog;
  logic             ped_pending;
  logic             state_chg;

  // A request arriving this very cycle counts, so a late request still exits
  // on the cycle it is seen once minimum green has elapsed.
  // Next-state selection; flash_en overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (flash_en) begin
      state_nxt = FLASH;
    end else begin
      case (state)
        MAIN_G: if (timer == GREEN_LAST ||
                    ((ped_pending || ped_req) && timer >= MIN_LAST))
                  state_nxt = MAIN_Y;
        MAIN_Y: if (timer == YELLOW_LAST) state_nxt = ALL_R1;
        ALL_R1: if (timer == ALLRED_LAST) state_nxt = SIDE_G;
        SIDE_G: if (timer == GREEN_LAST)  state_nxt = SIDE_Y;
        SIDE_Y: if (timer == YELLOW_LAST) state_nxt = ALL_R2;
        ALL_R2: if (timer == ALLRED_LAST) state_nxt = MAIN_G;
        FLASH:  state_nxt = ALL_R2;
        default: state_nxt = ALL_R2;
      endcase
    end
  end

  assign state_chg = (state_nxt != state);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MAIN_G;
    else     state <= state_nxt;
  end

  // Phase timer: restarts at every state change, otherwise counts up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            timer <= '0;
    else if (state_chg) timer <= '0;
    else                timer <= timer + CNT_W'(1);
  end

  // Blink divider, kept separate from the phase timer; restarts lit on FLASH entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt <= '0;
      flash_tog <= 1'b0;
    end else if (state != FLASH || state_nxt != FLASH) begin
      flash_cnt <= '0;
      flash_tog <= 1'b0;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_cnt <= '0;
      flash_tog <= ~flash_tog;
    end else begin
      flash_cnt <= flash_cnt + CNT_W'(1);
    end
  end

  // Pedestrian request latch: served on SIDE_G entry, frozen during SIDE_G and FLASH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ped_pending <= 1'b0;
    else if (state != SIDE_G && state_nxt == SIDE_G)
      ped_pending <= 1'b0;
    else if (ped_req && state != SIDE_G && state != FLASH)
      ped_pending <= 1'b1;
  end

  // Lamp and walk decode from the state register.
  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    ped_walk   = 1'b0;
    case (state)
      MAIN_G: main_light = LAMP_G;
      MAIN_Y: main_light = LAMP_Y;
      SIDE_G: begin
        side_light = LAMP_G;
        ped_walk   = 1'b1;
      end
      SIDE_Y: side_light = LAMP_Y;
      FLASH: begin
        main_light = flash_tog ? LAMP_OFF : LAMP_Y;
        side_light = flash_tog ? LAMP_OFF : LAMP_Y;
      end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Scoreboard bench: each test pushes its hand-derived per-cycle expectations,
// then drives inputs; a monitor pops one entry per cycle and compares.
module tb_traffic_light_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       ped_walk;

  traffic_light_ctrl_param dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .main_light(main_light), .side_light(side_light),
    .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  bit    checking = 1'b0;
  string tname    = "init";

  function automatic exp_t mk(int ph, bit off);
    exp_t e;
    e.ph = 3'(ph);
    e.w  = 1'b0;
    e.m  = 3'b001;
    e.s  = 3'b001;
    case (ph)
      0: e.m = 3'b100;
      1: e.m = 3'b010;
      3: begin e.s = 3'b100; e.w = 1'b1; end
      4: e.s = 3'b010;
      6: begin e.m = off ? 3'b000 : 3'b010; e.s = e.m; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic expect_run(int ph, int n, bit off = 1'b0);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(ph, off));
  endtask

  // 30-cycle default sequence
  task automatic expect_cycle();
    expect_run(0, 10); expect_run(1, 3); expect_run(2, 2);
    expect_run(3, 10); expect_run(4, 3); expect_run(5, 2);
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      exp_t e, a;
      a = {phase, main_light, side_light, ped_walk};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s cyc%0d underflow: got ph=%0d, want no output", tname, cyc, phase);
      end else begin
        e = exp_q.pop_front();
        if (a === e) n_pass++;
        else $display("FAIL %s cyc%0d: got ph=%0d m=%b s=%b w=%b, want ph=%0d m=%b s=%b w=%b",
                      tname, cyc, a.ph, a.m, a.s, a.w, e.ph, e.m, e.s, e.w);
      end
      n_checks++;
      if ($onehot0(main_light) && $onehot0(side_light) &&
          (phase == 3'd6 || main_light[2:1] == 2'b00 || side_light[2:1] == 2'b00))
        n_pass++;
      else
        $display("FAIL %s cyc%0d lamp_safety: got m=%b s=%b ph=%0d, want one-hot and no conflict",
                 tname, cyc, main_light, side_light, phase);
      cyc++;
    end
  end

  task automatic check_reset(string what);
    n_checks++;
    if ({phase, main_light, side_light, ped_walk} === {3'd0, 3'b100, 3'b001, 1'b0}) n_pass++;
    else $display("FAIL %s %s: got ph=%0d m=%b s=%b w=%b, want ph=0 m=100 s=001 w=0",
                  tname, what, phase, main_light, side_light, ped_walk);
  endtask

  // Assert reset asynchronously, check outputs at once, release off-edge.
  task automatic start_run();
    checking = 1'b0;
    rst      = 1'b1;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    #1;
    check_reset("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_held");
    #1;
    rst = 1'b0;
    cyc = 0;
    checking = 1'b1;
  endtask

  task automatic drive(int ncyc, int p0, int p1, int f_on, int f_off);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ped_req  = (c == p0) || (c == p1);
      flash_en = (c >= f_on) && (c < f_off);
    end
  endtask

  task automatic finish_run();
    #1;
    checking = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s drain: got %0d entries left, want 0", tname, exp_q.size());
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Defaults, no inputs: 10/3/2/10/3/2, period 30
    tname = "default";
    expect_cycle(); expect_cycle();
    start_run();
    drive(60, -1, -1, -1, -1);
    finish_run();

    // Early request: exit after timer=3, walk for all of SIDE_G
    tname = "ped_early";
    expect_run(0, 4); expect_run(1, 3); expect_run(2, 2);
    expect_run(3, 10); expect_run(4, 3); expect_run(5, 2);
    expect_run(0, 10); expect_run(1, 3);
    start_run();
    drive(37, 1, -1, -1, -1);
    finish_run();

    // Late request at timer=7: 8 green cycles; request during SIDE_G ignored
    tname = "ped_late";
    expect_run(0, 8); expect_run(1, 3); expect_run(2, 2);
    expect_run(3, 10); expect_run(4, 3); expect_run(5, 2);
    expect_run(0, 10); expect_run(1, 3);
    start_run();
    drive(41, 7, 15, -1, -1);
    finish_run();

    // Flash from SIDE_G: 5 lit / 5 dark blink; request in FLASH not latched
    tname = "flash";
    expect_run(0, 10); expect_run(1, 3); expect_run(2, 2); expect_run(3, 3);
    expect_run(6, 5, 0); expect_run(6, 5, 1); expect_run(6, 5, 0); expect_run(6, 2, 1);
    expect_run(5, 2); expect_run(0, 10); expect_run(1, 1);
    start_run();
    drive(48, 25, -1, 17, 34);
    finish_run();

    // Reset mid-SIDE_Y, off-edge: immediate reset outputs, then full MAIN_G
    tname = "rst_mid";
    expect_run(0, 10); expect_run(1, 3); expect_run(2, 2);
    expect_run(3, 10); expect_run(4, 2);
    start_run();
    drive(27, -1, -1, -1, -1);
    finish_run();
    #2;
    expect_run(0, 10); expect_run(1, 3); expect_run(2, 1);
    start_run();
    drive(14, -1, -1, -1, -1);
    finish_run();

    // Reset while in FLASH restarts from MAIN_G
    tname = "rst_flash";
    expect_run(0, 2); expect_run(6, 4, 0);
    start_run();
    drive(6, -1, -1, 1, 10);
    finish_run();
    #2;
    expect_run(0, 10); expect_run(1, 1);
    start_run();
    drive(11, -1, -1, -1, -1);
    finish_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_param.md
TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the phase timer.
REQ-002 SHALL have parameter GREEN_T, default 10: green duration in cycles, both roads.
REQ-003 SHALL have parameter YELLOW_T, default 3: yellow duration in cycles.
REQ-004 SHALL have parameter ALLRED_T, default 2: all-red clearance duration in cycles.
REQ-005 SHALL have parameter MIN_GREEN, default 4: minimum main green before a pedestrian cut-short.
REQ-006 SHALL have parameter FLASH_T, default 5: half-period of flash blinking, in cycles.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port ped_req, input, 1 bit: pedestrian crossing request, sampled every cycle.
REQ-010 SHALL have port flash_en, input, 1 bit: level request for flashing-yellow maintenance mode.
REQ-011 SHALL have port main_light, output, 3 bits: main road lamp, one-hot (red=001, yellow=010, green=100, off=000).
REQ-012 SHALL have port side_light, output, 3 bits: side road lamp, same encoding.
REQ-013 SHALL have port ped_walk, output, 1 bit: walk signal across the main road.
REQ-014 SHALL have port phase, output, 3 bits: current state code.

Function
REQ-015 SHALL implement states MAIN_G=0, MAIN_Y=1, ALL_R1=2, SIDE_G=3, SIDE_Y=4, ALL_R2=5, FLASH=6; phase equals the state code; code 7 SHALL recover to ALL_R2 on the next cycle.
REQ-016 SHALL use an up-counting CNT_W-bit timer, cleared to 0 on every state change, otherwise incremented by 1.
REQ-017 SHALL leave a timed state when timer==T-1 for that state (GREEN_T, YELLOW_T or ALLRED_T), so each state lasts exactly T cycles.
REQ-018 SHALL follow the order MAIN_G -> MAIN_Y -> ALL_R1 -> SIDE_G -> SIDE_Y -> ALL_R2 -> MAIN_G; default full cycle is 30 cycles.
REQ-019 SHALL decode lamps from the state register. MAIN_G: main green, side red. MAIN_Y: main yellow, side red. SIDE_G: main red, side green. SIDE_Y: main red, side yellow. ALL_R1 and ALL_R2: both red.
REQ-020 SHALL set a ped_pending flag on ped_req=1 in any state except SIDE_G; ped_req in SIDE_G SHALL be ignored.
REQ-021 SHALL clear ped_pending on entry to SIDE_G; ped_walk SHALL be 1 only in SIDE_G.
REQ-022 SHALL exit MAIN_G early when ped_pending=1 and timer>=MIN_GREEN-1; the normal exit at GREEN_T-1 still applies.
REQ-023 SHALL enter FLASH from any state on the cycle after flash_en=1 is sampled, clearing the timer; flash_en has priority over every other transition.
REQ-024 SHALL, in FLASH, show 010 on both lamps and ped_walk=0; lamps toggle between 010 and 000 every FLASH_T cycles, starting at 010.
REQ-025 SHALL leave FLASH for ALL_R2 the cycle after flash_en=0 is sampled; ped_pending SHALL be held unchanged through FLASH.
REQ-026 SHALL never show green or yellow on both roads together outside FLASH.
REQ-027 SHALL require all durations >=1, each <= 2^CNT_W-1, and MIN_GREEN<=GREEN_T; out-of-range values are unsupported.

Reset
REQ-028 SHALL, while rst=1, immediately force state=MAIN_G, timer=0, ped_pending=0, flash toggle=0, main_light=100, side_light=001, ped_walk=0, phase=0.
REQ-029 SHALL restart the full sequence from MAIN_G cycle 0 on the first clk edge after rst falls, including when reset is asserted mid-phase or in FLASH.

Verification
REQ-030 Defaults, no inputs, 60 cycles after reset -> phases 0,1,2,3,4,5 last 10,3,2,10,3,2 cycles and repeat with period 30.
REQ-031 ped_req pulse at MAIN_G timer=1 -> MAIN_Y entered after timer=3 (4 green cycles); ped_walk=1 for all 10 SIDE_G cycles, then 0.
REQ-032 ped_req pulse at MAIN_G timer=7 -> MAIN_Y entered the cycle after timer=7 (8 green cycles); ped_req during SIDE_G -> no early exit in the next MAIN_G.
REQ-033 flash_en=1 during SIDE_G -> FLASH next cycle; both lamps 010 for 5 cycles, 000 for 5, repeating; flash_en=0 -> ALL_R2 for 2 cycles, then MAIN_G.
REQ-034 rst pulse mid-SIDE_Y, not aligned to clk -> lamps 100/001 and phase=0 asynchronously; 10 MAIN_G cycles after release.
REQ-035 Every cycle of every test -> assert lamps one-hot or 000 and REQ-026 holds.
